// File: rtl/i2c_req_arbiter_pkg.sv
// i2c_req_arbiter_pkg: shared state encoding and byte constants
package i2c_req_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, STOP, ABORT, DONE} state_e;
  localparam int RW_BIT = 0;
  localparam int BYTE_W = 8;
  localparam int MAX_BYTES = 4;
endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester-side and i2c-master-side signals of the arbiter
interface i2c_req_arbiter_if #(parameter int N_REQ = 4);
  import i2c_req_arbiter_pkg::*;
  logic [N_REQ-1:0] req;
  logic [BYTE_W*N_REQ-1:0] req_addr;
  logic [BYTE_W*MAX_BYTES*N_REQ-1:0] req_wdata;
  logic [2*N_REQ-1:0] req_len;
  logic [N_REQ-1:0] done;
  logic err;
  logic err_to;
  logic [BYTE_W*MAX_BYTES-1:0] rdata;
  logic m_enable;
  logic [BYTE_W-1:0] m_addr;
  logic [BYTE_W-1:0] m_data;
  logic [BYTE_W-1:0] m_rdata;
  logic m_byte_done;
  logic m_nack;
  logic m_idle;
  modport master (
    input req, req_addr, req_wdata, req_len, m_rdata, m_byte_done, m_nack, m_idle,
    output done, err, err_to, rdata, m_enable, m_addr, m_data
  );
  modport slave (
    output req, req_addr, req_wdata, req_len, m_rdata, m_byte_done, m_nack, m_idle,
    input done, err, err_to, rdata, m_enable, m_addr, m_data
  );
endinterface

// File: rtl/i2c_req_arbiter_rr_picker.sv
// i2c_req_arbiter_rr_picker: first requester at or after ptr, searching upward with wrap
module i2c_req_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             valid
);
  int k;
  logic [PW-1:0] kk;
  always_comb begin
    idx = ptr;
    valid = |req;
    k = 0;
    kk = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      k = (k >= N_REQ) ? k - N_REQ : k;
      kk = PW'(k);
      idx = req[kk] ? kk : idx;
    end
  end
endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one i2c master among N_REQ requesters
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W = 13
) (
  input logic clk,
  input logic rst,
  i2c_req_arbiter_if.master bus
);
  localparam int PW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick;
  logic pick_v;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic [BYTE_W*MAX_BYTES-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [1:0] len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic perr_q, perr_d, pto_q, pto_d, err_q, err_d, err_to_q, err_to_d;
  logic tmo;
  i2c_req_arbiter_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req), .ptr(ptr_q), .idx(pick), .valid(pick_v)
  );
  assign tmo = cnt_q == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rbuf_d = rbuf_q;
    rdata_d = rdata_q;
    len_d = len_q;
    idx_d = idx_q;
    cnt_d = (state_q == ADDR || state_q == DATA) ? cnt_q + 1'b1 : '0;
    perr_d = perr_q;
    pto_d = pto_q;
    err_d = err_q;
    err_to_d = err_to_q;
    case (state_q)
      IDLE: if (bus.m_idle && pick_v) begin
        owner_d = pick;
        addr_d = bus.req_addr[BYTE_W*pick +: BYTE_W];
        wdata_d = bus.req_wdata[BYTE_W*MAX_BYTES*pick +: BYTE_W*MAX_BYTES];
        len_d = bus.req_len[2*pick +: 2];
        idx_d = '0;
        ptr_d = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        perr_d = 1'b0;
        pto_d = 1'b0;
        cnt_d = '0;
        state_d = ADDR;
      end
      ADDR: if (bus.m_nack) begin
        perr_d = 1'b1;
        state_d = ABORT;
      end else if (bus.m_byte_done) begin
        cnt_d = '0;
        state_d = DATA;
      end else if (tmo) begin
        perr_d = 1'b1;
        pto_d = 1'b1;
        state_d = ABORT;
      end
      DATA: if (bus.m_nack) begin
        perr_d = 1'b1;
        state_d = ABORT;
      end else if (bus.m_byte_done) begin
        if (addr_q[RW_BIT]) rbuf_d[BYTE_W*idx_q +: BYTE_W] = bus.m_rdata;
        idx_d = (idx_q == len_q) ? idx_q : idx_q + 1'b1;
        state_d = (idx_q == len_q) ? STOP : DATA;
        cnt_d = '0;
      end else if (tmo) begin
        perr_d = 1'b1;
        pto_d = 1'b1;
        state_d = ABORT;
      end
      STOP, ABORT: if (bus.m_idle) begin
        err_d = perr_q;
        err_to_d = pto_q;
        rdata_d = rbuf_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rbuf_q <= '0;
      rdata_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      perr_q <= 1'b0;
      pto_q <= 1'b0;
      err_q <= 1'b0;
      err_to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q <= rbuf_d;
      rdata_q <= rdata_d;
      len_q <= len_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      perr_q <= perr_d;
      pto_q <= pto_d;
      err_q <= err_d;
      err_to_q <= err_to_d;
    end
  assign bus.done = (state_q == DONE) ? N_REQ'(1) << owner_q : '0;
  assign bus.err = err_q;
  assign bus.err_to = err_to_q;
  assign bus.rdata = rdata_q;
  assign bus.m_enable = state_q == ADDR || state_q == DATA;
  assign bus.m_addr = addr_q;
  assign bus.m_data = wdata_q[BYTE_W*idx_q +: BYTE_W];
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: scoreboard bench with a simple i2c master model
module tb_i2c_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  typedef struct {
    logic [3:0] done;
    logic err;
    logic err_to;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb_q[$];
  logic [7:0] t_addr[4];
  logic [31:0] t_wd[4];
  logic [1:0] t_len[4];
  logic [31:0] exp_rd = '0;
  i2c_req_arbiter_if #(.N_REQ(4)) bus();
  i2c_req_arbiter #(.N_REQ(4), .TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] w, input logic [1:0] l);
    t_addr[i] = a;
    t_wd[i] = w;
    t_len[i] = l;
    bus.req_addr[8*i +: 8] = a;
    bus.req_wdata[32*i +: 32] = w;
    bus.req_len[2*i +: 2] = l;
  endtask
  task automatic pulse(input bit nack, input logic [7:0] rd);
    bus.m_byte_done = !nack;
    bus.m_nack = nack;
    bus.m_rdata = rd;
    @(negedge clk);
    bus.m_byte_done = 1'b0;
    bus.m_nack = 1'b0;
  endtask
  task automatic wait_en();
    int n = 0;
    while (!bus.m_enable && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("grant", bus.m_enable, 1);
  endtask
  task automatic xact(input int own, input int mode, input logic [31:0] rd, input logic [3:0] drop);
    sb_t e;
    int n;
    bit rd_op;
    rd_op = t_addr[own][0];
    if (mode == 0 && rd_op)
      for (int k = 0; k <= int'(t_len[own]); k++) exp_rd[8*k +: 8] = rd[8*k +: 8];
    e.done = 4'(1 << own);
    e.err = mode != 0;
    e.err_to = mode == 2;
    e.rdata = exp_rd;
    sb_q.push_back(e);
    wait_en();
    check("m_addr", bus.m_addr, t_addr[own]);
    bus.m_idle = 1'b0;
    @(negedge clk);
    if (mode == 1) pulse(1'b1, 8'h00);
    else begin
      pulse(1'b0, 8'h00);
      if (mode == 2) begin
        n = 0;
        while (bus.m_enable && n < 100) begin
          n++;
          @(negedge clk);
        end
        check("tmo_cycles", n, 16);
      end else
        for (int k = 0; k <= int'(t_len[own]); k++) begin
          @(negedge clk);
          if (!rd_op) check("m_data", bus.m_data, t_wd[own][8*k +: 8]);
          pulse(1'b0, rd[8*k +: 8]);
        end
    end
    check("en_off", bus.m_enable, 0);
    repeat (2) @(negedge clk);
    bus.m_idle = 1'b1;
    n = 0;
    while (bus.done == 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check("done", bus.done, e.done);
    check("err", bus.err, e.err);
    check("err_to", bus.err_to, e.err_to);
    check("rdata", bus.rdata, e.rdata);
    bus.req = bus.req & ~drop;
    @(negedge clk);
    check("done_width", bus.done, 0);
  endtask
  initial begin
    logic seen;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_len = '0;
    bus.m_rdata = '0;
    bus.m_byte_done = 1'b0;
    bus.m_nack = 1'b0;
    bus.m_idle = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_to", bus.err_to, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_en", bus.m_enable, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_data", bus.m_data, 0);
    rst = 1'b0;
    @(negedge clk);
    set_req(1, 8'h50, 32'h0000_BBAA, 2'd1);
    bus.req[1] = 1'b1;
    xact(1, 0, 32'h0, 4'b0010);
    set_req(0, 8'h51, 32'h0, 2'd3);
    bus.req[0] = 1'b1;
    xact(0, 0, 32'h4433_2211, 4'b0001);
    set_req(2, 8'h52, 32'h12, 2'd0);
    bus.req[2] = 1'b1;
    xact(2, 1, 32'h0, 4'b0100);
    set_req(3, 8'h54, 32'h34, 2'd2);
    bus.req[3] = 1'b1;
    xact(3, 2, 32'h0, 4'b1000);
    for (int i = 0; i < 4; i++) set_req(i, 8'h60 + 8'(2*i), 32'hA0B0_C0D0 + 32'(i), 2'(i));
    bus.req = 4'hF;
    for (int i = 0; i < 5; i++) xact(i % 4, 0, 32'h0, (i == 4) ? 4'hF : 4'h0);
    set_req(1, 8'h70, 32'hDDCC_BBAA, 2'd3);
    bus.req[1] = 1'b1;
    wait_en();
    check("m_addr_r", bus.m_addr, 8'h70);
    bus.m_idle = 1'b0;
    @(negedge clk);
    pulse(1'b0, 8'h00);
    @(negedge clk);
    pulse(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check("rst_mid_en", bus.m_enable, 0);
    exp_rd = '0;
    bus.req = '0;
    bus.m_idle = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | (|bus.done);
    end
    check("no_done_rst", seen, 0);
    set_req(0, 8'h72, 32'h99, 2'd0);
    set_req(2, 8'h74, 32'h88, 2'd0);
    bus.req = 4'b0101;
    xact(0, 0, 32'h0, 4'b0101);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one I2C master controller between N_REQ requesters.
- Each requester posts a complete transaction: 8-bit address (bit 0 = R/W) plus 1..4 data bytes.
- The block grants one requester, drives the master's enable/addr/data for address and data bytes, and collects read bytes.
- On completion it returns a done pulse with status to the granted requester. It sits between the system-side clients and the I2C master.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 4096, clk cycles allowed per byte phase without m_byte_done before abort.
- CNT_W, 13, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held high until its done pulse.
- req_addr  in  8*N_REQ  per-requester I2C address byte; slice i = [8i+7:8i].
- req_wdata  in  32*N_REQ  per-requester write bytes; byte k = bits [32i+8k+7:32i+8k], sent k=0 first.
- req_len  in  2*N_REQ  byte count minus 1 (0 means 1 byte, 3 means 4 bytes).
- done  out  N_REQ  one-cycle pulse to the owner on transaction end.
- err  out  1  valid with done; 1 = NACK or timeout.
- err_to  out  1  valid with done; 1 = abort caused by timeout.
- rdata  out  32  read bytes, byte k in [8k+7:8k]; valid with done for read transactions.
- m_enable  out  1  enable to the I2C master.
- m_addr  out  8  address byte to the master.
- m_data  out  8  current write byte to the master.
- m_rdata  in  8  byte read by the master; valid when m_byte_done is high.
- m_byte_done  in  1  one-cycle pulse: address or data byte finished and ACKed.
- m_nack  in  1  one-cycle pulse: NACK received.
- m_idle  in  1  master in IDLE with the bus released.

Behaviour:
- Reset, asynchronous and effective immediately:
  - state IDLE; rr_ptr=0.
  - All outputs 0: done, err, err_to, rdata, m_enable, m_addr, m_data.
- Asserting rst mid-transaction drops m_enable at once. The master returns itself to idle; no done pulse is issued.
- Registers: state, owner index, latched addr/wdata/len, byte index idx (2 bits), timeout counter, rdata shift storage.
- FSM:
  - IDLE: when m_idle=1 and |req, select the first requester with req high, searching from rr_ptr upward with wrap. Latch its addr/wdata/len; set idx=0; rr_ptr <= owner+1 (mod N_REQ); go to ADDR. Arbitration decision takes 1 cycle.
  - ADDR: m_enable=1, m_addr=latched addr, m_data=wdata byte 0.
    - m_byte_done goes to DATA.
    - m_nack goes to ABORT.
    - Timeout goes to ABORT with err_to=1.
  - DATA: m_data = wdata byte idx.
    - On m_byte_done: if read (addr[0]=1), store m_rdata into rdata byte idx. If idx==len go to STOP, else idx++ and reset the timeout counter.
    - m_nack goes to ABORT. Timeout goes to ABORT.
  - STOP: m_enable=0; wait for m_idle=1, then go to DONE.
  - ABORT: m_enable=0; set err=1 (err_to set if the cause was timeout); wait for m_idle=1, then go to DONE.
  - DONE: done[owner]=1 for exactly 1 cycle together with err/err_to/rdata; return to IDLE. err/err_to/rdata hold their values until the next DONE.
- Timeout counter: clears on entering ADDR/DATA and on each m_byte_done; increments otherwise in those states. Reaching TIMEOUT-1 triggers abort.
- Priority within a cycle: m_nack > m_byte_done > timeout.
- Simultaneous requests: round-robin only. A requester dropping req mid-transaction does not cancel it; it completes and done still pulses.
- A requester is never re-granted in the cycle after its done pulse unless it is the only one requesting.
- m_addr is held stable from ADDR until IDLE.
- rdata bytes beyond len keep their previous values.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, ADDR, DATA, STOP, ABORT, DONE).
  - R/W bit position constant (0).
  - byte width 8; max bytes 4.
- One sub-module is natural: rr_picker, a combinational round-robin priority encoder (req vector, rr_ptr to owner index and valid).

Test Plan:
- Single write: req[1]=1, addr=0x50, len=1, wdata=0x0000_BBAA. Model byte_done ×3, then m_idle. Required: m_data=0xAA then 0xBB, then done[1] with err=0, rr_ptr=2.
- Read 4 bytes: req[0], addr=0x51, len=3; m_rdata 0x11,0x22,0x33,0x44. Required: rdata=0x4433_2211 at done[0], err=0.
- Address NACK: req[2], m_nack during ADDR. Required: m_enable falls next cycle; after m_idle, done[2] with err=1, err_to=0.
- Fairness: req=4'b1111 held, each transaction completes. Required: grant order 0,1,2,3,0 with rr_ptr wrapping.
- Timeout: TIMEOUT=16, no byte_done in DATA. Required: ABORT entered after 16 cycles; done with err=1, err_to=1.
- Reset mid-DATA: assert rst. Required: m_enable=0 immediately, no done pulse; after release, a new request is granted starting from requester 0.
